plru_tree_replacer: RTL

- Parametrised tree pseudo-LRU replacement unit for the N-way set-associative caches.
- Supersedes the fixed 4-way combinational picker. Adds:
  - any power-of-two way count;
  - a registered one-cycle lookup/response pipeline with same-set forwarding;
  - a per-way lock mask;
  - a bulk clear sequencer.
- Sits beside the tag array. The cache controller issues one lookup per access and consumes the response to steer the refill.

---
 rtl/plru_pkg.sv | 38 +++
 rtl/plru_tree_pick.sv | 54 +++++
 rtl/plru_tree_replacer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/plru_pkg.sv
// Shared helpers for the tree pseudo-LRU replacer.
// Heap-ordered tree: node i has children 2i+1 and 2i+2.
package plru_pkg;

  localparam logic [15:0] NO_WAY = '0;

  function automatic int left_child(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int right_child(input int n);
    return 2 * n + 2;
  endfunction

  function automatic int parent(input int n);
    return (n - 1) / 2;
  endfunction

  function automatic logic path_bit(input int w, input int l, input int ww);
    return logic'((w >> (ww - 1 - l)) & 1);
  endfunction

  // Child of node n on the root-to-leaf route, or -1 when n is off the route.
  function automatic int path_child(input int n, input int leaf);
    int x;
    int r;
    x = leaf;
    r = -1;
    for (int i = 0; i < 8; i++) begin
      if (x > n) begin
        if (parent(x) == n) r = x;
        x = parent(x);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/plru_tree_pick.sv
// Combinational victim picker: invalid-first, then a lock-aware tree walk.
// A subtree whose ways are all locked is skipped in favour of its sibling.
module plru_tree_pick
  import plru_pkg::*;
#(
  parameter int WAY_NUM = 4
) (
  input  logic [WAY_NUM-2:0] tree,
  input  logic [WAY_NUM-1:0] valid,
  input  logic [WAY_NUM-1:0] lock,
  output logic [WAY_NUM-1:0] victim,
  output logic               none
);

  localparam int NODES = 2 * WAY_NUM - 1;

  logic [NODES-1:0]   all_lk;
  logic [NODES-1:0]   reach;
  logic [WAY_NUM-1:0] free_oh;
  logic               found;
  logic               go_r;

  always_comb begin
    all_lk = '0;
    reach = '0;
    go_r = 1'b0;
    found = 1'b0;
    victim = '0;
    for (int w = 0; w < WAY_NUM; w++)
      all_lk[WAY_NUM-1+w] = lock[w];
    for (int n = WAY_NUM - 2; n >= 0; n--)
      all_lk[n] = all_lk[left_child(n)] & all_lk[right_child(n)];

    reach[0] = 1'b1;
    for (int n = 0; n < WAY_NUM - 1; n++) begin
      go_r = tree[n] ? ~all_lk[right_child(n)] : all_lk[left_child(n)];
      reach[left_child(n)]  = reach[n] & ~go_r;
      reach[right_child(n)] = reach[n] & go_r;
    end

    free_oh = ~valid & ~lock;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (free_oh[w] && !found) begin
        victim[w] = 1'b1;
        found = 1'b1;
      end
    end
    if (!found) victim = reach[NODES-1 -: WAY_NUM];

    none = &lock;
    if (none) victim = '0;
  end

endmodule

// File: rtl/plru_tree_replacer.sv
// Tree pseudo-LRU replacement unit: one-cycle lookup pipeline,
// same-set forwarding, per-way locks and a bulk clear sweep.
module plru_tree_replacer
  import plru_pkg::*;
#(
  parameter int WAY_NUM     = 4,
  parameter int INDEX_WIDTH = 6,
  parameter int WAY_W       = $clog2(WAY_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lookup_valid,
  output logic                   lookup_ready,
  input  logic [INDEX_WIDTH-1:0] lookup_index,
  input  logic [WAY_NUM-1:0]     lookup_hit,
  input  logic [WAY_NUM-1:0]     lookup_way_valid,
  input  logic [WAY_NUM-1:0]     lookup_way_lock,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [WAY_NUM-1:0]     resp_way,
  output logic [WAY_W-1:0]       resp_way_id,
  output logic                   resp_none,
  input  logic                   clear_req,
  output logic                   clear_busy
);

  localparam int LINE_NUM = 2 ** INDEX_WIDTH;
  localparam int TB = WAY_NUM - 1;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic [TB-1:0]          tree_q [LINE_NUM];

  logic                   r_valid;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [WAY_NUM-1:0]     r_hit;
  logic [WAY_NUM-1:0]     r_vmask;
  logic [WAY_NUM-1:0]     r_lock;
  logic [TB-1:0]          r_tree;

  logic                   acc;
  logic                   is_hit;
  logic                   none;
  logic                   pick_none;
  logic                   touch_en;
  logic [WAY_NUM-1:0]     hit_oh;
  logic [WAY_NUM-1:0]     pick_oh;
  logic [WAY_NUM-1:0]     sel_oh;
  logic [WAY_W-1:0]       sel_id;
  logic [TB-1:0]          touched;
  logic [TB-1:0]          rd_tree;

  assign lookup_ready = (state_q == IDLE);
  assign clear_busy   = (state_q == CLEAR);
  assign acc          = lookup_valid & lookup_ready;

  plru_tree_pick #(
    .WAY_NUM(WAY_NUM)
  ) u_pick (
    .tree  (r_tree),
    .valid (r_vmask),
    .lock  (r_lock),
    .victim(pick_oh),
    .none  (pick_none)
  );

  always_comb begin
    is_hit = |r_hit;
    hit_oh = r_hit & (~r_hit + WAY_NUM'(1));
    sel_oh = is_hit ? hit_oh : pick_oh;
    none   = ~is_hit & pick_none;
    sel_id = '0;
    for (int w = 0; w < WAY_NUM; w++)
      if (sel_oh[w]) sel_id = WAY_W'(w);
    // Point every node on the selected way's path away from it.
    touched = r_tree;
    for (int n = 0; n < TB; n++) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        if (sel_oh[w] && path_child(n, TB + w) == left_child(n))
          touched[n] = 1'b1;
        else if (sel_oh[w] && path_child(n, TB + w) == right_child(n))
          touched[n] = 1'b0;
      end
    end
  end

  assign touch_en = r_valid & ~none;

  assign rd_tree = (touch_en && r_index == lookup_index) ?
                   touched : tree_q[lookup_index];

  assign resp_valid  = r_valid;
  assign resp_hit    = r_valid & is_hit;
  assign resp_none   = r_valid & none;
  assign resp_way    = r_valid ? sel_oh : WAY_NUM'(NO_WAY);
  assign resp_way_id = r_valid ? sel_id : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_index <= '0;
      r_hit   <= '0;
      r_vmask <= '0;
      r_lock  <= '0;
      r_tree  <= '0;
    end else begin
      r_valid <= acc;
      if (acc) begin
        r_index <= lookup_index;
        r_hit   <= lookup_hit;
        r_vmask <= lookup_way_valid;
        r_lock  <= lookup_way_lock;
        r_tree  <= rd_tree;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_NUM; i++)
        tree_q[i] <= '0;
    end else if (state_q == CLEAR) begin
      tree_q[cnt_q] <= '0;
    end else if (touch_en) begin
      tree_q[r_index] <= touched;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A lookup in the same cycle as clear_req is served first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req && !lookup_valid) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + INDEX_WIDTH'(1);
        if (&cnt_q) state_d = IDLE;
      end
    endcase
  end

endmodule
